// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one synchronous single-port RAM.
// Alternating priority on contention; read data is returned the cycle after the grant.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  logic prio;       // 0: A preferred, 1: B preferred
  logic rd_pend_a;
  logic rd_pend_b;

  // Winner selection; reset forces the port idle without waiting for a clock edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (req_a && req_b) begin
      gnt_a = ~prio;
      gnt_b = prio;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    ram_din  = {DATA_W{1'b0}};
    ram_we   = 1'b0;
    case ({gnt_a, gnt_b})
      2'b10: begin
        ram_addr = addr_a;
        ram_din  = wdata_a;
        ram_we   = we_a;
      end
      2'b01: begin
        ram_addr = addr_b;
        ram_din  = wdata_b;
        ram_we   = we_b;
      end
      default: begin
        ram_addr = {ADDR_W{1'b0}};
        ram_din  = {DATA_W{1'b0}};
        ram_we   = 1'b0;
      end
    endcase
  end

  // Priority flips toward the loser on every grant; reads are tracked for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      rd_pend_a <= gnt_a & ~we_a;
      rd_pend_b <= gnt_b & ~we_b;
      if (gnt_a || gnt_b) begin
        prio <= gnt_a;
      end else begin
        prio <= prio;
      end
    end
  end

  assign rvalid_a = rd_pend_a;
  assign rvalid_b = rd_pend_b;
  assign rdata_a  = rd_pend_a ? ram_dout : {DATA_W{1'b0}};
  assign rdata_b  = rd_pend_b ? ram_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural arbitration/RAM model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          req_a, we_a, gnt_a, rvalid_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a, rdata_a;
  logic          req_b, we_b, gnt_b, rvalid_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b, rdata_b;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: synchronous, read-before-write, driven only by the DUT's port.
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int tests = 0;
  int fails = 0;

  // Model state: who is preferred next, which read returns next cycle, and its data.
  logic [DW-1:0] mem_m [256];
  logic          b_pref, pend_a, pend_b, nx_a, nx_b;
  logic [DW-1:0] m_rdata;
  int            ca, cb, cboth, act;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    b_pref  = 1'b0;
    pend_a  = 1'b0;
    pend_b  = 1'b0;
    m_rdata = 8'h00;
    nx_a    = 1'b0;
    nx_b    = 1'b0;
  endtask

  // Mid-cycle: work out who must win from the rules, then check every output.
  task automatic sample();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_we;
    @(negedge clk);
    if (rst) begin
      nx_a = 1'b0;
      nx_b = 1'b0;
    end else begin
      nx_a = req_a && (!req_b || !b_pref);
      nx_b = req_b && !nx_a;
    end
    e_addr = nx_a ? addr_a  : (nx_b ? addr_b  : 8'h00);
    e_din  = nx_a ? wdata_a : (nx_b ? wdata_b : 8'h00);
    e_we   = nx_a ? we_a    : (nx_b ? we_b    : 1'b0);
    chk("gnt_a", gnt_a, nx_a);
    chk("gnt_b", gnt_b, nx_b);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("rvalid_a", rvalid_a, pend_a);
    chk("rvalid_b", rvalid_b, pend_b);
    chk("rdata_a", rdata_a, pend_a ? m_rdata : 8'h00);
    chk("rdata_b", rdata_b, pend_b ? m_rdata : 8'h00);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pend_a = nx_a && !we_a;
      pend_b = nx_b && !we_b;
      if (nx_a && !we_a) m_rdata = mem_m[addr_a];
      if (nx_b && !we_b) m_rdata = mem_m[addr_b];
      if (nx_a && we_a) mem_m[addr_a] = wdata_a;
      if (nx_b && we_b) mem_m[addr_b] = wdata_b;
      if (nx_a || nx_b) b_pref = nx_a;
    end
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_a = r; we_a = w; addr_a = ad; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_b = r; we_b = w; addr_b = ad; wdata_b = d;
  endtask

  initial begin
    rst = 1'b1;
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    sample();
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    advance();
    rst = 1'b0;

    // Lone A write right after reset, then contention shows B is now preferred.
    set_a(1'b1, 1'b1, 8'h02, 8'hCC);
    sample();
    chk("lone_gnt_a", gnt_a, 1'b1);
    chk("lone_ram_we", ram_we, 1'b1);
    chk("lone_ram_addr", ram_addr, 8'h02);
    chk("lone_ram_din", ram_din, 8'hCC);
    advance();
    set_a(1'b1, 1'b1, 8'h20, 8'h01);
    set_b(1'b1, 1'b1, 8'h21, 8'h02);
    sample();
    chk("prio_flip_gnt_b", gnt_b, 1'b1);
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);

    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;

    // Both write the same address: A first, then B, last writer wins.
    set_a(1'b1, 1'b1, 8'h0A, 8'hCC);
    set_b(1'b1, 1'b1, 8'h0A, 8'hAA);
    sample();
    chk("same_c1_gnt_a", gnt_a, 1'b1);
    chk("same_c1_din", ram_din, 8'hCC);
    advance();
    sample();
    chk("same_c2_gnt_b", gnt_b, 1'b1);
    chk("same_c2_din", ram_din, 8'hAA);
    advance();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    set_a(1'b1, 1'b0, 8'h0A, 8'h00);
    sample();
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("same_rd_rvalid_a", rvalid_a, 1'b1);
    chk("same_rd_rdata_a", rdata_a, 8'hAA);
    advance();

    // Pre-load, then dual read returns on consecutive cycles.
    set_a(1'b1, 1'b1, 8'h03, 8'h11);
    sample();
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b1, 1'b1, 8'h04, 8'h22);
    sample();
    advance();
    set_a(1'b1, 1'b0, 8'h03, 8'h00);
    set_b(1'b1, 1'b0, 8'h04, 8'h00);
    sample();
    chk("dual_rd_gnt_a", gnt_a, 1'b1);
    chk("dual_rd_gnt_b0", gnt_b, 1'b0);
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("dual_rd_gnt_b", gnt_b, 1'b1);
    chk("dual_rd_rvalid_a", rvalid_a, 1'b1);
    chk("dual_rd_rdata_a", rdata_a, 8'h11);
    advance();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("dual_rd_rvalid_b", rvalid_b, 1'b1);
    chk("dual_rd_rdata_b", rdata_b, 8'h22);
    chk("dual_rd_rvalid_a0", rvalid_a, 1'b0);
    advance();

    // Sustained contention: strict alternation, four grants each.
    set_a(1'b1, 1'b0, 8'h03, 8'h00);
    set_b(1'b1, 1'b0, 8'h04, 8'h00);
    ca = 0; cb = 0; cboth = 0;
    repeat (8) begin
      sample();
      ca += int'(gnt_a);
      cb += int'(gnt_b);
      cboth += int'(gnt_a & gnt_b);
      advance();
    end
    chk("alt_count_a", ca, 4);
    chk("alt_count_b", cb, 4);
    chk("alt_count_both", cboth, 0);
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("alt_last_rvalid_b", rvalid_b, 1'b1);
    advance();

    // Idle: nothing happens and priority is preserved.
    act = 0;
    repeat (5) begin
      sample();
      act += int'(gnt_a | gnt_b | ram_we | rvalid_a | rvalid_b);
      advance();
    end
    chk("idle_activity", act, 0);
    set_a(1'b1, 1'b0, 8'h03, 8'h00);
    set_b(1'b1, 1'b0, 8'h04, 8'h00);
    sample();
    chk("idle_prio_gnt_a", gnt_a, 1'b1);
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);

    // Read granted to B, reset lands before the data would return.
    set_b(1'b1, 1'b0, 8'h05, 8'h00);
    sample();
    chk("rstmid_gnt_b", gnt_b, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_gnt_b0", gnt_b, 1'b0);
    chk("rstmid_ram_addr", ram_addr, 8'h00);
    chk("rstmid_ram_we", ram_we, 1'b0);
    chk("rstmid_rvalid_a", rvalid_a, 1'b0);
    chk("rstmid_rdata_a", rdata_a, 8'h00);
    model_reset();
    advance();
    rst = 1'b0;
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("rstmid_no_rvalid_b", rvalid_b, 1'b0);
    advance();
    set_a(1'b1, 1'b1, 8'h30, 8'h5A);
    set_b(1'b1, 1'b1, 8'h31, 8'hA5);
    sample();
    chk("rstmid_first_gnt_a", gnt_a, 1'b1);
    advance();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, address width of each requester and the RAM port.
REQ-002 Parameter: DATA_W, 8, data width of each requester and the RAM port.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_a  input  1  requester A access request, held until granted.
REQ-006 Port: we_a  input  1  requester A write (1) / read (0) select.
REQ-007 Port: addr_a  input  ADDR_W  requester A address.
REQ-008 Port: wdata_a  input  DATA_W  requester A write data.
REQ-009 Port: gnt_a  output  1  requester A access issued this cycle.
REQ-010 Port: rvalid_a  output  1  requester A read data valid.
REQ-011 Port: rdata_a  output  DATA_W  requester A read data.
REQ-012 Ports req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b SHALL mirror REQ-005..REQ-011 for requester B.
REQ-013 Port: ram_addr  output  ADDR_W  address to the single RAM port.
REQ-014 Port: ram_din  output  DATA_W  write data to the RAM port.
REQ-015 Port: ram_we  output  1  RAM write enable.
REQ-016 Port: ram_dout  input  DATA_W  RAM synchronous read data, valid the cycle after the address is presented.

Function
REQ-017 The block SHALL issue at most one RAM access per cycle; gnt_a and gnt_b SHALL never be high together.
REQ-018 Grant SHALL be combinational from req_a, req_b and a registered priority bit prio (0 = A preferred, 1 = B preferred).
REQ-019 Only one requester asserting req SHALL be granted that cycle regardless of prio.
REQ-020 Both requesting SHALL grant the preferred requester per prio.
REQ-021 On any grant, prio SHALL update at the clock edge to prefer the non-granted requester; with no grant, prio SHALL hold.
REQ-022 In a grant cycle, ram_addr/ram_din/ram_we SHALL equal the winner's addr/wdata/we; with no grant, ram_we SHALL be 0 and ram_addr/ram_din SHALL be 0.
REQ-023 A requester SHALL treat gnt high at a rising edge as acceptance; it may change or drop req and operands from the next cycle.
REQ-024 A granted read (we=0) SHALL set the winner's rvalid exactly one cycle later for one cycle; a granted write SHALL produce no rvalid.
REQ-025 rdata_x SHALL equal ram_dout when rvalid_x is high and 0 otherwise.
REQ-026 Back-to-back reads by alternating requesters SHALL produce rvalid on consecutive cycles, each on the correct requester.
REQ-027 A continuously requesting requester SHALL wait at most one cycle for a grant (strict alternation when both request every cycle).

Reset
REQ-028 While rst is high: gnt_a, gnt_b, ram_we, rvalid_a, rvalid_b = 0; ram_addr, ram_din, rdata_a, rdata_b = 0; prio = 0.
REQ-029 rst asserted mid-operation SHALL immediately clear outputs; a read issued in the cycle before reset SHALL not produce rvalid after reset release.
REQ-030 After rst deasserts, the first cycle with both requesting SHALL grant A.

Verification
REQ-031 Reset release, req_a=1 we_a=1 addr_a=0x02 wdata_a=0xCC, req_b=0 -> gnt_a=1, ram_we=1, ram_addr=0x02, ram_din=0xCC same cycle; prio becomes 1.
REQ-032 Both write same cycle, addr 0x0A, wdata_a=0xCC, wdata_b=0xAA, held 2 cycles after reset -> cycle 1 gnt_a, cycle 2 gnt_b; reading 0x0A afterward returns 0xAA.
REQ-033 Pre-load 0x03=0x11, 0x04=0x22; both read (A 0x03, B 0x04) -> gnt_a then gnt_b; rvalid_a/rdata_a=0x11 then rvalid_b/rdata_b=0x22 on consecutive cycles.
REQ-034 Both hold req for 8 cycles -> grants strictly alternate A,B,A,B,...; never both high; 4 grants each.
REQ-035 Read grant to B at 0x05, rst pulsed before next edge -> rvalid_b stays 0, all outputs 0 during rst, next dual request grants A.
REQ-036 No requests for 5 cycles -> gnt_a=gnt_b=ram_we=rvalid_*=0, prio unchanged.
